// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand-forwarding selects, load-use stall and branch
// flush control for the 5-stage RISC-V pipeline. It keeps a shadow copy of
// the EX/MEM/WB destination and result-type information.
module hazard_fwd_ctrl #(
  parameter int XLEN_REGS = 32,
  parameter int CNT_W     = 16,
  localparam int RW       = $clog2(XLEN_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_reg_write,
  input  logic [1:0]       id_result_src,
  input  logic             ex_pc_src,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  // Result-source encodings
  localparam logic [1:0] RSRC_ALU  = 2'b00;
  localparam logic [1:0] RSRC_LOAD = 2'b01;

  // Mux select encodings
  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_AUX  = 2'b11;

  logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic          ex_use1, ex_use2, ex_rw;
  logic [1:0]    ex_rsrc;
  logic [RW-1:0] mem_rd;
  logic          mem_rw;
  logic [1:0]    mem_rsrc;
  logic [RW-1:0] wb_rd;
  logic          wb_rw;
  logic          lu;

  // MEM has priority over WB. A load sitting in MEM cannot be forwarded,
  // so it falls through to the WB check. x0 is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic          used,
    input logic [RW-1:0] rs,
    input logic          m_rw,
    input logic [RW-1:0] m_rd,
    input logic [1:0]    m_rsrc,
    input logic          w_rw,
    input logic [RW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = SEL_REG;
    if (used && rs != '0 && m_rw && m_rd == rs && m_rsrc != RSRC_LOAD)
      sel = (m_rsrc == RSRC_ALU) ? SEL_MEM : SEL_AUX;
    else if (w_rw && w_rd == rs && rs != '0)
      sel = SEL_WB;
    return sel;
  endfunction

  // Shadow pipeline: advance MEM->WB and EX->MEM; EX takes a bubble on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_use1  <= 1'b0;
      ex_use2  <= 1'b0;
      ex_rd    <= '0;
      ex_rw    <= 1'b0;
      ex_rsrc  <= 2'b00;
      mem_rd   <= '0;
      mem_rw   <= 1'b0;
      mem_rsrc <= 2'b00;
      wb_rd    <= '0;
      wb_rw    <= 1'b0;
    end else begin
      wb_rd    <= mem_rd;
      wb_rw    <= mem_rw;
      mem_rd   <= ex_rd;
      mem_rw   <= ex_rw;
      mem_rsrc <= ex_rsrc;
      if (flush_e) begin
        ex_rs1  <= '0;
        ex_rs2  <= '0;
        ex_use1 <= 1'b0;
        ex_use2 <= 1'b0;
        ex_rd   <= '0;
        ex_rw   <= 1'b0;
        ex_rsrc <= 2'b00;
      end else begin
        ex_rs1  <= id_rs1;
        ex_rs2  <= id_rs2;
        ex_use1 <= id_use_rs1;
        ex_use2 <= id_use_rs2;
        ex_rd   <= id_rd;
        ex_rw   <= id_reg_write;
        ex_rsrc <= id_result_src;
      end
    end
  end

  // Forward selects come only from registered shadow state
  always_comb begin
    fwd_a_sel = fwd_select(ex_use1, ex_rs1, mem_rw, mem_rd, mem_rsrc, wb_rw, wb_rd);
    fwd_b_sel = fwd_select(ex_use2, ex_rs2, mem_rw, mem_rd, mem_rsrc, wb_rw, wb_rd);
  end

  // Load in EX feeding the ID instruction; a taken branch overrides the stall
  always_comb begin
    lu = ex_rw && (ex_rsrc == RSRC_LOAD) && (ex_rd != '0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    stall_f = lu && !ex_pc_src;
    stall_d = lu && !ex_pc_src;
    flush_d = ex_pc_src;
    flush_e = ex_pc_src || lu;
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lu_stall_cnt <= '0;
    else if (stall_d && lu_stall_cnt != {CNT_W{1'b1}})
      lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
  end

  // A load in MEM matching an EX source means a stall was missed upstream
  a_no_load_fwd_a: assert property (@(posedge clk) disable iff (rst)
    !(ex_use1 && ex_rs1 != '0 && mem_rw && mem_rsrc == RSRC_LOAD && mem_rd == ex_rs1));
  a_no_load_fwd_b: assert property (@(posedge clk) disable iff (rst)
    !(ex_use2 && ex_rs2 != '0 && mem_rw && mem_rsrc == RSRC_LOAD && mem_rd == ex_rs2));

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed instruction sequences with hand-computed
// forwarding, stall, flush and counter expectations.
module tb_hazard_fwd_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write;
  logic [1:0]  id_result_src;
  logic        ex_pc_src;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [15:0] lu_stall_cnt;

  int testCount;
  int failCount;

  hazard_fwd_ctrl #(.XLEN_REGS(32), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_result_src (id_result_src),
    .ex_pc_src     (ex_pc_src),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .lu_stall_cnt  (lu_stall_cnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one instruction in ID plus the branch-resolution input
  task automatic applyStimulus(input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic rw,
                               input logic [1:0] rsrc, input logic pcsrc);
    id_rs1        = rs1;
    id_use_rs1    = u1;
    id_rs2        = rs2;
    id_use_rs2    = u2;
    id_rd         = rd;
    id_reg_write  = rw;
    id_result_src = rsrc;
    ex_pc_src     = pcsrc;
    #1;
  endtask

  // Advance one clock; inputs change and outputs are sampled after the negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkSels(input string tag, input logic [1:0] a, input logic [1:0] b);
    checkOutput({tag, "_a"}, 32'(fwd_a_sel), 32'(a));
    checkOutput({tag, "_b"}, 32'(fwd_b_sel), 32'(b));
  endtask

  task automatic checkCtrl(input string tag, input logic sf, input logic sd,
                           input logic fd, input logic fe);
    checkOutput({tag, "_ctrl"}, {28'd0, stall_f, stall_d, flush_d, flush_e},
                {28'd0, sf, sd, fd, fe});
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkSels("reset_sel", 2'b00, 2'b00);
    checkCtrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_cnt", 32'(lu_stall_cnt), 32'd0);

    // Start a load-use stall, then assert reset mid-cycle with random inputs
    applyStimulus(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 1'b0);
    tick();
    applyStimulus(5'd4, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 2'b00, 1'b0);
    checkCtrl("pre_reset_stall", 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    applyStimulus(5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1,
                  2'($urandom), 1'b0);
    checkSels("async_reset_sel", 2'b00, 2'b00);
    checkCtrl("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("async_reset_cnt", 32'(lu_stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    checkOutput("post_reset_cnt", 32'(lu_stall_cnt), 32'd0);
    tick();
    tick();

    // ALU back-to-back: add x5 ; sub x6,x5,x5 ; add x10 ; and x11,x6,x6
    applyStimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'b00, 1'b0);
    tick();
    applyStimulus(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
    tick();
    checkSels("alu_b2b", 2'b10, 2'b10);
    applyStimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 2'b00, 1'b0);
    checkCtrl("alu_no_stall", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkSels("indep", 2'b00, 2'b00);
    applyStimulus(5'd6, 1'b1, 5'd6, 1'b1, 5'd11, 1'b1, 2'b00, 1'b0);
    tick();
    checkSels("wb_fwd", 2'b01, 2'b01);

    // Aux forward: lui x7 ; add x8,x7,x0
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b11, 1'b0);
    tick();
    applyStimulus(5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 2'b00, 1'b0);
    tick();
    checkSels("aux_fwd", 2'b11, 2'b00);

    // x0: write x0 then read x0
    applyStimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 2'b00, 1'b0);
    tick();
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 2'b00, 1'b0);
    tick();
    checkSels("x0_no_fwd", 2'b00, 2'b00);

    // Double hit: add x3 ; add x3 ; reader x3 -> MEM wins
    applyStimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'b00, 1'b0);
    tick();
    applyStimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'b00, 1'b0);
    tick();
    applyStimulus(5'd3, 1'b1, 5'd1, 1'b1, 5'd13, 1'b1, 2'b00, 1'b0);
    tick();
    checkSels("double_hit", 2'b10, 2'b00);

    // Load-use: lw x4 ; add x9,x4,x1
    applyStimulus(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 1'b0);
    checkCtrl("lw_in_id", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd4, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 2'b00, 1'b0);
    checkCtrl("lu_stall", 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("lu_cnt_before", 32'(lu_stall_cnt), 32'd0);
    tick();
    checkCtrl("lu_released", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_cnt_after", 32'(lu_stall_cnt), 32'd1);
    checkSels("lu_bubble", 2'b00, 2'b00);
    tick();
    checkSels("lu_wb_fwd", 2'b01, 2'b00);
    checkOutput("lu_cnt_hold", 32'(lu_stall_cnt), 32'd1);

    // Branch vs load-use in the same cycle: flush wins, no stall
    applyStimulus(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 1'b0);
    tick();
    applyStimulus(5'd4, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 2'b00, 1'b1);
    checkCtrl("br_vs_lu", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    checkOutput("br_cnt", 32'(lu_stall_cnt), 32'd1);
    checkSels("br_bubble", 2'b00, 2'b00);

    // Saturation: one below all-ones reaches 0xFFFF and then holds
    force dut.lu_stall_cnt = 16'hFFFE;
    #1;
    release dut.lu_stall_cnt;
    #1;
    checkOutput("preload", 32'(lu_stall_cnt), 32'h0000FFFE);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 1'b0);
      tick();
      applyStimulus(5'd0, 1'b0, 5'd4, 1'b1, 5'd15, 1'b1, 2'b00, 1'b0);
      checkCtrl("sat_stall", 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("sat_cnt", 32'(lu_stall_cnt), 32'h0000FFFF);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
